// File: rtl/jk_eval_pkg.sv
// Shared types and the fixed J/K stimulus table
// for the JK cell evaluation driver.
package jk_eval_pkg;

  typedef logic [1:0] jk_vec_t;

  localparam jk_vec_t JK_HOLD   = 2'b00;
  localparam jk_vec_t JK_RESET  = 2'b01;
  localparam jk_vec_t JK_SET    = 2'b10;
  localparam jk_vec_t JK_TOGGLE = 2'b11;

  localparam int JK_NUM = 16;

  localparam jk_vec_t JK_VECTORS [JK_NUM] = '{
    JK_SET,    JK_HOLD,  JK_RESET, JK_HOLD,
    JK_SET,    JK_SET,   JK_RESET, JK_RESET,
    JK_HOLD,   JK_TOGGLE, JK_RESET, JK_SET,
    JK_HOLD,   JK_TOGGLE, JK_SET,   JK_HOLD
  };

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    APPLY,
    SAMPLE,
    FINISH
  } state_t;

  // 11 is only meaningful as a score when toggles are checked
  function automatic logic is_scored(
    jk_vec_t v,
    logic    check_toggle
  );
    return !(v == JK_TOGGLE && !check_toggle);
  endfunction

endpackage

// File: rtl/jk_golden_model.sv
// Reference JK state tracked alongside the applied vectors,
// plus the decision whether the current vector is scored.
module jk_golden_model
  import jk_eval_pkg::*;
#(
  parameter bit CHECK_TOGGLE = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    init,
  input  logic    upd,
  input  jk_vec_t upd_vec,
  input  jk_vec_t cur_vec,
  output logic    golden_q,
  output logic    golden_valid,
  output logic    check
);

  logic q_base;
  logic v_base;
  logic q_next;
  logic v_next;

  // init and a same-cycle update compose: update applies on top of init
  always_comb begin
    q_base = init ? 1'b0 : golden_q;
    v_base = init ? 1'b1 : golden_valid;
    q_next = q_base;
    v_next = v_base;
    if (upd) begin
      case (upd_vec)
        JK_RESET: begin
          q_next = 1'b0;
          v_next = 1'b1;
        end
        JK_SET: begin
          q_next = 1'b1;
          v_next = 1'b1;
        end
        JK_TOGGLE: begin
          if (CHECK_TOGGLE) q_next = ~q_base;
          else              v_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      golden_q     <= 1'b0;
      golden_valid <= 1'b0;
    end else begin
      golden_q     <= q_next;
      golden_valid <= v_next;
    end
  end

  assign check = golden_valid && is_scored(cur_vec, CHECK_TOGGLE);

endmodule

// File: rtl/jk_eval_driver.sv
// Applies the J/K vector table to one evolved JK cell,
// samples its synchronized Q and scores it against a golden model.
module jk_eval_driver
  import jk_eval_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_VECTORS   = 16,
  parameter bit CHECK_TOGGLE  = 1'b0,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [1:0]       dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] scored_count
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = 4;
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_VECTORS - 1);

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] cnt;
  logic [SW-1:0] cnt_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic          q_m;
  logic          q_s;
  logic          init;
  logic          upd;
  logic          check;
  logic          golden_q;
  logic          golden_valid;
  jk_vec_t       cur_vec;
  jk_vec_t       upd_vec;

  assign cur_vec = JK_VECTORS[idx];
  assign upd_vec = JK_VECTORS[idx_n];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    init    = 1'b0;
    upd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = INIT;
          cnt_n   = '0;
        end
      end
      INIT: begin
        init = 1'b1;
        if (cnt == SLAST) begin
          state_n = APPLY;
          cnt_n   = '0;
          idx_n   = '0;
          upd     = 1'b1;
        end else begin
          cnt_n = cnt + SW'(1);
        end
      end
      APPLY: begin
        if (cnt == SLAST) begin
          state_n = SAMPLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + SW'(1);
        end
      end
      SAMPLE: begin
        if (idx == ILAST) begin
          state_n = FINISH;
        end else begin
          state_n = APPLY;
          idx_n   = idx + IW'(1);
          upd     = 1'b1;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      q_m          <= 1'b0;
      q_s          <= 1'b0;
      err_count    <= '0;
      scored_count <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      q_m   <= dut_out;
      q_s   <= q_m;
      if (state == IDLE && start) begin
        err_count    <= '0;
        scored_count <= '0;
      end else if (state == SAMPLE && check) begin
        scored_count <= scored_count + CNT_W'(1);
        if (q_s != golden_q)
          err_count <= err_count + CNT_W'(1);
      end
    end
  end

  jk_golden_model #(
    .CHECK_TOGGLE(CHECK_TOGGLE)
  ) u_golden (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .upd         (upd),
    .upd_vec     (upd_vec),
    .cur_vec     (cur_vec),
    .golden_q    (golden_q),
    .golden_valid(golden_valid),
    .check       (check)
  );

  // decoded from state so async reset forces 00 immediately
  always_comb begin
    dut_in = JK_HOLD;
    if (state == INIT)
      dut_in = JK_RESET;
    else if (state == APPLY || state == SAMPLE)
      dut_in = cur_vec;
  end

  assign busy = (state == INIT) || (state == APPLY) ||
                (state == SAMPLE);
  assign done = (state == FINISH);
  assign pass = ((state == IDLE) || (state == FINISH)) &&
                (err_count == '0) && (scored_count != '0);

endmodule

// File: tb/tb_jk_eval_driver.sv
// Scoreboard bench: two driver instances (defaults, and S=3 with
// toggle checking) each driving a behavioural JK cell.
module tb_jk_eval_driver;

  typedef struct {
    int err;
    int scored;
    int pass;
    int done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start   [2];
  logic [1:0] dut_in  [2];
  logic       dut_out [2];
  logic       busy    [2];
  logic       done    [2];
  logic       pass    [2];
  logic [4:0] err_c   [2];
  logic [4:0] scr_c   [2];

  int   mode [2];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t me;

  logic [1:0] tbl [16] = '{2'b10, 2'b00, 2'b01, 2'b00,
                           2'b10, 2'b10, 2'b01, 2'b01,
                           2'b00, 2'b11, 2'b01, 2'b10,
                           2'b00, 2'b11, 2'b10, 2'b00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jk_eval_driver u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .dut_in(dut_in[0]), .dut_out(dut_out[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_c[0]), .scored_count(scr_c[0])
  );

  jk_eval_driver #(
    .SETTLE_CYCLES(3), .NUM_VECTORS(16),
    .CHECK_TOGGLE(1'b1), .CNT_W(5)
  ) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .dut_in(dut_in[1]), .dut_out(dut_out[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_c[1]), .scored_count(scr_c[1])
  );

  // evaluated cell: ideal JK reacting once per input change,
  // optionally stuck or delayed by whole clocks
  logic       q_id [2];
  logic [1:0] last [2];
  logic [3:0] hist [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (dut_in[g] != last[g]) begin
        case (dut_in[g])
          2'b01:   q_id[g] = 1'b0;
          2'b10:   q_id[g] = 1'b1;
          2'b11:   q_id[g] = ~q_id[g];
          default: ;
        endcase
      end
      last[g] = dut_in[g];
      hist[g] = {hist[g][2:0], q_id[g]};
      case (mode[g])
        0:       dut_out[g] = q_id[g];
        1:       dut_out[g] = 1'b0;
        2:       dut_out[g] = 1'b1;
        3:       dut_out[g] = hist[g][1];
        default: dut_out[g] = hist[g][3];
      endcase
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // md: 0 ideal, 1 stuck 0, 2 stuck 1, 3 fast delay, 4 late delay
  task automatic ref_eval(input bit ct, input int md,
                          output int e, output int s);
    bit q, pq, g, gv, obs;
    q = 0; g = 0; gv = 1; e = 0; s = 0;
    for (int i = 0; i < 16; i++) begin
      pq = q;
      case (tbl[i])
        2'b01: begin q = 0; g = 0; gv = 1; end
        2'b10: begin q = 1; g = 1; gv = 1; end
        2'b11: begin
          q = ~q;
          if (ct) g = ~g;
          else    gv = 0;
        end
        default: ;
      endcase
      if (gv && (ct || tbl[i] != 2'b11)) begin
        s++;
        case (md)
          1:       obs = 0;
          2:       obs = 1;
          4:       obs = pq;
          default: obs = q;
        endcase
        if (obs != g) e++;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (done[g]) begin
        if ((g == 0 ? q0.size() : q1.size()) == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done inst%0d: got 1 expected 0", g);
        end else begin
          me = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk("err_count", int'(err_c[g]), me.err);
          chk("scored_count", int'(scr_c[g]), me.scored);
          chk("pass", int'(pass[g]), me.pass);
          chk("done_cycle", cyc, me.done_cyc);
        end
      end
    end
  end

  task automatic issue(int g, int md);
    exp_t e;
    int   ee, ss, lat;
    ref_eval(g == 1, md, ee, ss);
    lat = (g == 0) ? 86 : 69;
    @(negedge clk);
    start[g] = 1'b1;
    e.err = ee;
    e.scored = ss;
    e.pass = (ee == 0 && ss > 0) ? 1 : 0;
    e.done_cyc = cyc + lat - 1;
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    start[g] = 1'b0;
    chk("busy_after_start", int'(busy[g]), 1);
  endtask

  task automatic run(int g, int md, int gap, bit rp, bit fs);
    mode[g] = md;
    repeat (gap) @(negedge clk);
    issue(g, md);
    for (int k = 1; k < 200 && !done[g]; k++) begin
      if (rp && (k == 10 || k == 50)) start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
    end
    if (!done[g]) begin
      tests++;
      fails++;
      $display("FAIL done_timeout inst%0d: got 0 expected 1", g);
    end else if (fs) begin
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      chk("start_in_finish_busy", int'(busy[g]), 0);
    end
  endtask

  task automatic chk_zero(int g, string tag);
    chk({tag, "_dut_in"}, int'(dut_in[g]), 0);
    chk({tag, "_busy"}, int'(busy[g]), 0);
    chk({tag, "_done"}, int'(done[g]), 0);
    chk({tag, "_pass"}, int'(pass[g]), 0);
    chk({tag, "_err"}, int'(err_c[g]), 0);
    chk({tag, "_scored"}, int'(scr_c[g]), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      mode[g]  = 0;
      q_id[g]  = 1'b0;
      last[g]  = 2'b00;
      hist[g]  = 4'h0;
      dut_out[g] = 1'b0;
    end
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(0, 0, 2, 1'b1, 1'b1);
    run(0, 1, 0, 1'b0, 1'b0);
    run(0, 2, 0, 1'b0, 1'b1);
    run(1, 0, 2, 1'b0, 1'b0);
    run(1, 3, 1, 1'b1, 1'b0);
    run(1, 4, 1, 1'b0, 1'b1);
    run(0, 4, 1, 1'b0, 1'b0);

    // asynchronous reset in the middle of an evaluation
    mode[0] = 0;
    issue(0, 0);
    repeat (38) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero(0, "midrst");
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    run(0, 0, 1, 1'b0, 1'b0);

    for (int r = 0; r < 14; r++) begin
      run($urandom_range(0, 1), $urandom_range(0, 4),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("pending_q0", q0.size(), 0);
    chk("pending_q1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
